// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-control bundle between the EX-stage datapath (master) and ex_hazard_ctrl (slave).
interface ex_hazard_ctrl_if;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic       RegWrite_M, RegWrite_W, ResultSrcLd_E, PCSrc_E, MCStart_E;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M, Busy_E;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
           RegWrite_M, RegWrite_W, ResultSrcLd_E, PCSrc_E, MCStart_E,
    input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
           Flush_D, Flush_E, Bubble_M, Busy_E
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
           RegWrite_M, RegWrite_W, ResultSrcLd_E, PCSrc_E, MCStart_E,
    output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
           Flush_D, Flush_E, Bubble_M, Busy_E
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: operand forwarding, load-use stall, branch flush and
// a counter FSM that holds EX for multi-cycle ops while bubbling MEM.
module ex_fwd_sel (
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       regwrite_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       regwrite_w_i,
  output logic [1:0] fwd_o
);
  // MEM is younger than WB, so its value wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_o = 2'b00;
    if (regwrite_m_i && rd_m_i != 5'd0 && rd_m_i == rs_i)      fwd_o = 2'b10;
    else if (regwrite_w_i && rd_w_i != 5'd0 && rd_w_i == rs_i) fwd_o = 2'b01;
  end
endmodule

module ex_hazard_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input logic           clk,
  input logic           rst_n,
  ex_hazard_ctrl_if.slave hz
);
  localparam int NUM_OPS = 2;
  localparam bit MC_EN   = (MC_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MC_LATENCY > 1) ? MC_LATENCY - 2 : 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mc_stall, lw_stall;

  logic [NUM_OPS-1:0][4:0] rs_e;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign rs_e = {hz.Rs2_E, hz.Rs1_E};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    ex_fwd_sel u_fwd (
      .rs_i         (rs_e[g]),
      .rd_m_i       (hz.Rd_M),
      .regwrite_m_i (hz.RegWrite_M),
      .rd_w_i       (hz.Rd_W),
      .regwrite_w_i (hz.RegWrite_W),
      .fwd_o        (fwd[g])
    );
  end

  assign lw_stall = hz.ResultSrcLd_E && (hz.Rd_E != 5'd0) &&
                    ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle stalls combinationally, so BUSY only needs MC_LATENCY-2 more stall cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MC_EN && hz.MCStart_E && !hz.PCSrc_E) begin
          mc_stall = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output, forwarding included, is held low while reset is asserted.
  always_comb begin
    hz.ForwardA_E = 2'b00;
    hz.ForwardB_E = 2'b00;
    hz.Stall_F    = 1'b0;
    hz.Stall_D    = 1'b0;
    hz.Stall_E    = 1'b0;
    hz.Flush_D    = 1'b0;
    hz.Flush_E    = 1'b0;
    hz.Bubble_M   = 1'b0;
    hz.Busy_E     = 1'b0;
    if (rst_n) begin
      hz.ForwardA_E = fwd[0];
      hz.ForwardB_E = fwd[1];
      hz.Busy_E     = (state_q == BUSY);
      if (mc_stall) begin
        hz.Stall_F  = 1'b1;
        hz.Stall_D  = 1'b1;
        hz.Stall_E  = 1'b1;
        hz.Bubble_M = 1'b1;
      end else if (hz.PCSrc_E) begin
        hz.Flush_D  = 1'b1;
        hz.Flush_E  = 1'b1;
      end else if (lw_stall) begin
        hz.Stall_F  = 1'b1;
        hz.Stall_D  = 1'b1;
        hz.Flush_E  = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: op-age reference model checked every negedge plus directed literals.
module tb_ex_hazard_ctrl;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   op_age = -1;  // cycles the current multi-cycle op has spent in EX, -1 when none

  ex_hazard_ctrl_if hz ();
  ex_hazard_ctrl #(.MC_LATENCY(L), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_m(input logic [4:0] rs);
    if (hz.RegWrite_M && hz.Rd_M != 0 && hz.Rd_M == rs) return 2'b10;
    if (hz.RegWrite_W && hz.Rd_W != 0 && hz.Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int eff_age();
    if (op_age < 0 && hz.MCStart_E && !hz.PCSrc_E && L > 1) return 0;
    return op_age;
  endfunction

  function automatic logic [10:0] exp_m();
    logic lw, pc, mc;
    int e;
    if (!rst_n) return '0;
    lw = hz.ResultSrcLd_E && hz.Rd_E != 0 && (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
    pc = hz.PCSrc_E;
    e  = eff_age();
    mc = (e >= 0) && (e < L - 1);
    return {fwd_m(hz.Rs1_E), fwd_m(hz.Rs2_E), mc | (!pc & lw), mc | (!pc & lw), mc,
            !mc & pc, !mc & (pc | lw), mc, 1'(op_age >= 1)};
  endfunction

  function automatic logic [10:0] act_v();
    return {hz.ForwardA_E, hz.ForwardB_E, hz.Stall_F, hz.Stall_D, hz.Stall_E,
            hz.Flush_D, hz.Flush_E, hz.Bubble_M, hz.Busy_E};
  endfunction

  // {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M}
  function automatic logic [5:0] ctl();
    return {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_D, hz.Flush_E, hz.Bubble_M};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_age <= -1;
    else if (eff_age() >= 0 && eff_age() < L - 1) op_age <= eff_age() + 1;
    else op_age <= -1;
  end

  always @(negedge clk) chk("model", 16'(act_v()), 16'(exp_m()));

  task automatic clr();
    hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0;
    hz.Rd_E = 0; hz.Rd_M = 0; hz.Rd_W = 0;
    hz.RegWrite_M = 0; hz.RegWrite_W = 0; hz.ResultSrcLd_E = 0;
    hz.PCSrc_E = 0; hz.MCStart_E = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] spat, bpat;
    clr();
    hz.Rs1_E = 5; hz.Rd_M = 5; hz.RegWrite_M = 1;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 16'(act_v()), 16'h0);
    nxt();
    rst_n = 1;
    clr();

    // forwarding
    hz.Rs1_E = 5; hz.Rd_M = 5; hz.RegWrite_M = 1; hz.Rd_W = 5; hz.RegWrite_W = 1;
    @(negedge clk); chk("fwdA_mem_prio", 16'(hz.ForwardA_E), 16'h2);
    nxt(); hz.RegWrite_M = 0;
    @(negedge clk); chk("fwdA_wb", 16'(hz.ForwardA_E), 16'h1);
    nxt(); hz.Rd_M = 0; hz.Rd_W = 0; hz.Rs1_E = 0;
    @(negedge clk); chk("fwdA_none", 16'(hz.ForwardA_E), 16'h0);
    nxt(); hz.Rs2_E = 9; hz.Rd_W = 9; hz.RegWrite_W = 1;
    @(negedge clk); chk("fwdB_wb", 16'(hz.ForwardB_E), 16'h1);
    nxt(); hz.Rs2_E = 0; hz.Rd_M = 0; hz.RegWrite_M = 1; hz.Rd_W = 0;
    @(negedge clk); chk("fwdB_x0", 16'(hz.ForwardB_E), 16'h0);

    // load-use and branch
    nxt(); clr(); hz.ResultSrcLd_E = 1; hz.Rd_E = 7; hz.Rs2_D = 7;
    @(negedge clk); chk("loaduse", 16'(ctl()), 16'b110010);
    nxt(); hz.Rd_E = 0;
    @(negedge clk); chk("loaduse_x0", 16'(ctl()), 16'h0);
    nxt(); hz.Rd_E = 7; hz.PCSrc_E = 1;
    @(negedge clk); chk("branch_wins", 16'(ctl()), 16'b000110);
    nxt(); clr();

    // single hold, with a branch and a WB forward landing mid-hold
    spat = 8'b0000_0111; bpat = 8'b0000_1110;
    hz.MCStart_E = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin hz.Rd_W = 3; hz.RegWrite_W = 1; hz.Rs1_E = 3; end
      if (i == 2) begin hz.PCSrc_E = 1; hz.ResultSrcLd_E = 1; hz.Rd_E = 4; hz.Rs1_D = 4; end
      if (i == 3) begin hz.PCSrc_E = 0; hz.ResultSrcLd_E = 0; end
      @(negedge clk);
      chk($sformatf("hold_stall%0d", i), 16'(hz.Stall_F), 16'(spat[i]));
      chk($sformatf("hold_busy%0d", i), 16'(hz.Busy_E), 16'(bpat[i]));
      if (i == 1) chk("hold_fwd_wb", 16'(hz.ForwardA_E), 16'h1);
      if (i == 2) chk("hold_over_branch", 16'(ctl()), 16'b111001);
      nxt();
    end
    clr();
    @(negedge clk); chk("after_hold", 16'({hz.Stall_F, hz.Busy_E}), 16'h0);
    nxt();

    // back-to-back holds
    spat = 8'b0111_0111; bpat = 8'b1110_1110;
    hz.MCStart_E = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_stall%0d", i), 16'(hz.Stall_F), 16'(spat[i]));
      chk($sformatf("b2b_bubble%0d", i), 16'(hz.Bubble_M), 16'(spat[i]));
      chk($sformatf("b2b_busy%0d", i), 16'(hz.Busy_E), 16'(bpat[i]));
      nxt();
    end
    clr();
    @(negedge clk);
    nxt();

    // async reset in cycle 1 of a hold
    hz.MCStart_E = 1;
    @(negedge clk);
    nxt();
    chk("pre_rst_busy", 16'(hz.Busy_E), 16'h1);
    hz.Rs1_E = 6; hz.Rd_M = 6; hz.RegWrite_M = 1;
    rst_n = 0;
    #1 chk("async_rst", 16'(act_v()), 16'h0);
    hz.MCStart_E = 0;
    @(negedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), 16'({hz.Busy_E, hz.Stall_F}), 16'h0);
    end
    nxt(); clr();

    // mixed stimulus over a small register range, checked by the model
    for (int i = 0; i < 80; i++) begin
      hz.Rs1_D = 5'($urandom_range(0, 3)); hz.Rs2_D = 5'($urandom_range(0, 3));
      hz.Rs1_E = 5'($urandom_range(0, 3)); hz.Rs2_E = 5'($urandom_range(0, 3));
      hz.Rd_E  = 5'($urandom_range(0, 3)); hz.Rd_M  = 5'($urandom_range(0, 3));
      hz.Rd_W  = 5'($urandom_range(0, 3));
      hz.RegWrite_M = 1'($urandom_range(0, 1)); hz.RegWrite_W = 1'($urandom_range(0, 1));
      hz.ResultSrcLd_E = 1'($urandom_range(0, 1));
      hz.PCSrc_E   = ($urandom_range(0, 3) == 0);
      hz.MCStart_E = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
